soc_riscv_cpu2ahb: RTL



---
 rtl/soc_riscv_cpu2ahb_pkg.sv | 12 +
 rtl/soc_riscv_cpu2ahb_if.sv | 37 +++
 rtl/soc_riscv_cpu2ahb_be2size.sv | 22 ++
 rtl/soc_riscv_cpu2ahb.sv | 88 ++++++++
 4 files changed

// File: rtl/soc_riscv_cpu2ahb_pkg.sv
// soc_riscv_cpu2ahb_pkg: AHB3-Lite encodings shared by the CPU-to-AHB bridge
package soc_riscv_cpu2ahb_pkg;
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HSIZE_BYTE    = 3'b000;
    localparam logic [2:0] HSIZE_HALF    = 3'b001;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [2:0] HSIZE_DWORD   = 3'b011;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic       HRESP_OKAY    = 1'b0;
    localparam logic       HRESP_ERROR   = 1'b1;
endpackage

// File: rtl/soc_riscv_cpu2ahb_if.sv
// soc_riscv_cpu2ahb_if: CPU memory port plus AHB3-Lite master signals seen by the bridge
interface soc_riscv_cpu2ahb_if #(
    parameter int XLEN           = 32,
    parameter int PHYS_ADDR_SIZE = XLEN
);
    logic                      mem_req;
    logic [XLEN-1:0]           mem_adr;
    logic                      mem_we;
    logic [XLEN/8-1:0]         mem_be;
    logic [XLEN-1:0]           mem_d;
    logic [XLEN-1:0]           mem_q;
    logic                      mem_ack;
    logic                      mem_err;
    logic                      mem_misaligned;
    logic                      HSEL;
    logic [PHYS_ADDR_SIZE-1:0] HADDR;
    logic [XLEN-1:0]           HWDATA;
    logic [XLEN-1:0]           HRDATA;
    logic                      HWRITE;
    logic [2:0]                HSIZE;
    logic [2:0]                HBURST;
    logic [3:0]                HPROT;
    logic [1:0]                HTRANS;
    logic                      HMASTLOCK;
    logic                      HREADY;
    logic                      HRESP;
    modport master (
        input  mem_req, mem_adr, mem_we, mem_be, mem_d, HRDATA, HREADY, HRESP,
        output mem_q, mem_ack, mem_err, mem_misaligned, HSEL, HADDR, HWDATA,
               HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK
    );
    modport slave (
        output mem_req, mem_adr, mem_we, mem_be, mem_d, HRDATA, HREADY, HRESP,
        input  mem_q, mem_ack, mem_err, mem_misaligned, HSEL, HADDR, HWDATA,
               HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK
    );
endinterface

// File: rtl/soc_riscv_cpu2ahb_be2size.sv
// soc_riscv_cpu2ahb_be2size: accepts only naturally aligned power-of-two byte masks matching the address
module soc_riscv_cpu2ahb_be2size #(
    parameter int XLEN = 32
) (
    input  logic [XLEN/8-1:0]         be,
    input  logic [$clog2(XLEN/8)-1:0] adr,
    output logic                      legal,
    output logic [2:0]                hsize
);
    localparam int NB = XLEN / 8;
    localparam int AW = $clog2(NB);
    always_comb begin
        legal = 1'b0;
        hsize = 3'd0;
        for (int s = 0; s <= AW; s++)
            for (int o = 0; o < NB; o += (1 << s))
                if (be == (NB'((1 << (1 << s)) - 1) << o) && adr == AW'(o)) begin
                    legal = 1'b1;
                    hsize = 3'(s);
                end
    end
endmodule

// File: rtl/soc_riscv_cpu2ahb.sv
// soc_riscv_cpu2ahb: turns single-outstanding CPU requests into AHB3-Lite SINGLE transfers
module soc_riscv_cpu2ahb
    import soc_riscv_cpu2ahb_pkg::*;
#(
    parameter int         XLEN           = 32,
    parameter int         PHYS_ADDR_SIZE = XLEN,
    parameter logic [3:0] HPROT_VAL      = 4'b0011
) (
    input logic HCLK,
    input logic HRESETn,
    soc_riscv_cpu2ahb_if.master bus
);
    localparam int AW = $clog2(XLEN / 8);
    typedef enum logic [1:0] {IDLE, ADDR, DATA, ERR} state_t;
    state_t          state;
    logic            legal;
    logic [2:0]      size;
    logic [XLEN-1:0] d;
    soc_riscv_cpu2ahb_be2size #(.XLEN(XLEN)) u_be2size (
        .be    (bus.mem_be),
        .adr   (bus.mem_adr[AW-1:0]),
        .legal (legal),
        .hsize (size)
    );
    assign bus.HBURST    = HBURST_SINGLE;
    assign bus.HPROT     = HPROT_VAL;
    assign bus.HMASTLOCK = 1'b0;
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state              <= IDLE;
            d                  <= '0;
            bus.HTRANS         <= HTRANS_IDLE;
            bus.HSEL           <= 1'b0;
            bus.HADDR          <= '0;
            bus.HWDATA         <= '0;
            bus.HWRITE         <= 1'b0;
            bus.HSIZE          <= HSIZE_BYTE;
            bus.mem_q          <= '0;
            bus.mem_ack        <= 1'b0;
            bus.mem_err        <= 1'b0;
            bus.mem_misaligned <= 1'b0;
        end else begin
            bus.mem_ack        <= 1'b0;
            bus.mem_err        <= 1'b0;
            bus.mem_misaligned <= 1'b0;
            case (state)
                IDLE: if (bus.mem_req) begin
                    if (legal) begin
                        bus.HTRANS <= HTRANS_NONSEQ;
                        bus.HSEL   <= 1'b1;
                        bus.HADDR  <= bus.mem_adr[PHYS_ADDR_SIZE-1:0];
                        bus.HWRITE <= bus.mem_we;
                        bus.HSIZE  <= size;
                        d          <= bus.mem_d;
                        state      <= ADDR;
                    end else
                        bus.mem_misaligned <= 1'b1;
                end
                ADDR: if (bus.HREADY) begin
                    bus.HTRANS <= HTRANS_IDLE;
                    bus.HSEL   <= 1'b0;
                    bus.HWDATA <= d;
                    state      <= DATA;
                end
                // An ERROR seen together with HREADY is completed at once rather than via ERR
                DATA: if (bus.HRESP == HRESP_ERROR) begin
                    if (bus.HREADY) begin
                        bus.mem_err <= 1'b1;
                        bus.mem_q   <= '0;
                        state       <= IDLE;
                    end else
                        state <= ERR;
                end else if (bus.HREADY) begin
                    bus.mem_ack <= 1'b1;
                    if (!bus.HWRITE) bus.mem_q <= bus.HRDATA;
                    state <= IDLE;
                end
                ERR: if (bus.HREADY) begin
                    bus.mem_err <= 1'b1;
                    bus.mem_q   <= '0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
    assert property (@(posedge HCLK) disable iff (!HRESETn) !(bus.mem_req && state != IDLE));
endmodule
